rs_dec_scheduler: RTL and testbench

Sequencer that sits in front of RS_dec and paces an upstream valid/ready byte stream into the decoder's CE-strobed input. It enforces the minimum CE spacing and frames 204-byte codewords. It limits the number of codewords in flight and re-frames the decoder's CEO/Valid_out output into a 188-byte stream with start and end markers.

---
 rtl/rs_dec_scheduler_pkg.sv | 20 ++
 rtl/rs_dec_scheduler_if.sv | 62 ++++++
 rtl/rs_dec_scheduler_pacer.sv | 63 ++++++
 rtl/rs_dec_scheduler.sv | 140 ++++++++++++++
 tb/tb_rs_dec_scheduler.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/rs_dec_scheduler_pkg.sv
// Shared constants and types for the RS decoder input/output scheduler.
// Index widths, default codeword geometry and the issue-FSM state enum.
package rs_dec_pkg;

  localparam int RS_N        = 204;
  localparam int RS_K        = 188;
  localparam int RS_MIN_GAP  = 6;
  localparam int RS_MAX_INFL = 3;
  localparam int IDX_W       = 8;
  localparam int BYTE_W      = 8;
  localparam int CRED_W      = 3;
  localparam int CNT_W       = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STROBE,
    ST_GAP
  } issue_st_e;

endpackage

// File: rtl/rs_dec_scheduler_if.sv
// Bus bundle between the scheduler, its upstream source, the RS decoder
// and the downstream sink.
interface rs_dec_scheduler_if
  import rs_dec_pkg::*;
;

  logic              s_valid;
  logic [BYTE_W-1:0] s_data;
  logic              s_ready;
  logic              dec_ce;
  logic [BYTE_W-1:0] dec_byte;
  logic [BYTE_W-1:0] dec_out_byte;
  logic              dec_ceo;
  logic              dec_valid;
  logic              m_valid;
  logic [BYTE_W-1:0] m_data;
  logic              m_sop;
  logic              m_eop;
  logic [CRED_W-1:0] inflight;
  logic              err_unexp;
  logic [CNT_W-1:0]  in_cw_cnt;
  logic [CNT_W-1:0]  out_cw_cnt;

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready,
    output dec_ce,
    output dec_byte,
    input  dec_out_byte,
    input  dec_ceo,
    input  dec_valid,
    output m_valid,
    output m_data,
    output m_sop,
    output m_eop,
    output inflight,
    output err_unexp,
    output in_cw_cnt,
    output out_cw_cnt
  );

  modport master (
    output s_valid,
    output s_data,
    input  s_ready,
    input  dec_ce,
    input  dec_byte,
    output dec_out_byte,
    output dec_ceo,
    output dec_valid,
    input  m_valid,
    input  m_data,
    input  m_sop,
    input  m_eop,
    input  inflight,
    input  err_unexp,
    input  in_cw_cnt,
    input  out_cw_cnt
  );

endinterface

// File: rtl/rs_dec_scheduler_pacer.sv
// Issue FSM for the RS decoder CE strobe: one accept, one CE pulse,
// then GAP idle cycles before the next byte may be taken.
module rs_dec_pacer
  import rs_dec_pkg::*;
#(
  parameter int GAP = RS_MIN_GAP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic [BYTE_W-1:0] data_i,
  input  logic              credit_ok_i,
  output logic              ready_o,
  output logic              accept_o,
  output logic              ce_o,
  output logic [BYTE_W-1:0] byte_o
);

  localparam logic [7:0] GAP_M1 = 8'(GAP - 1);

  issue_st_e         st_q;
  logic [7:0]        gap_q;
  logic              ce_q;
  logic [BYTE_W-1:0] byte_q;

  assign ready_o  = (st_q == ST_IDLE) && credit_ok_i && !reset;
  assign accept_o = valid_i && ready_o;
  assign ce_o     = ce_q;
  assign byte_o   = byte_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q   <= ST_IDLE;
      gap_q  <= '0;
      ce_q   <= 1'b0;
      byte_q <= '0;
    end else begin
      unique case (st_q)
        ST_IDLE: begin
          if (accept_o) begin
            byte_q <= data_i;
            ce_q   <= 1'b1;
            st_q   <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          ce_q  <= 1'b0;
          gap_q <= GAP_M1;
          st_q  <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_q == 8'd0) begin
            st_q <= ST_IDLE;
          end else begin
            gap_q <= gap_q - 8'd1;
          end
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rs_dec_scheduler.sv
// RS decoder scheduler: paces input bytes, tracks codeword credit and
// frames decoder output. Optional counters under RS_SCHED_STATS_EN.
module rs_dec_scheduler
  import rs_dec_pkg::*;
#(
  parameter int N_IN         = RS_N,
  parameter int N_OUT        = RS_K,
  parameter int GAP          = RS_MIN_GAP,
  parameter int MAX_INFLIGHT = RS_MAX_INFL
) (
  input  logic clk,
  input  logic reset,
  rs_dec_scheduler_if.slave bus
);

  localparam logic [IDX_W-1:0]  IN_LAST  = IDX_W'(N_IN - 1);
  localparam logic [IDX_W-1:0]  OUT_LAST = IDX_W'(N_OUT - 1);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(MAX_INFLIGHT);

  logic [IDX_W-1:0]  in_idx_q, in_idx_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
  logic [CRED_W-1:0] inflight_q, inflight_d;
  logic              err_q;
  logic              m_valid_q;
  logic [BYTE_W-1:0] m_data_q;
  logic              m_sop_q;
  logic              m_eop_q;

  logic accept;
  logic credit_ok;
  logic evt;
  logic cred_inc;
  logic cred_dec;
  logic in_wrap;

  // Credit only gates the first byte of a codeword.
  assign credit_ok = !((in_idx_q == '0) && (inflight_q == CRED_MAX));

  rs_dec_pacer #(
    .GAP (GAP)
  ) u_pacer (
    .clk         (clk),
    .reset       (reset),
    .valid_i     (bus.s_valid),
    .data_i      (bus.s_data),
    .credit_ok_i (credit_ok),
    .ready_o     (bus.s_ready),
    .accept_o    (accept),
    .ce_o        (bus.dec_ce),
    .byte_o      (bus.dec_byte)
  );

  assign evt      = bus.dec_valid && bus.dec_ceo;
  assign in_wrap  = accept && (in_idx_q == IN_LAST);
  assign cred_inc = accept && (in_idx_q == '0);
  assign cred_dec = evt && (out_idx_q == OUT_LAST)
                 && (inflight_q != '0);

  always_comb begin
    in_idx_d = in_idx_q;
    if (accept) begin
      in_idx_d = in_wrap ? '0 : in_idx_q + 1'b1;
    end
  end

  always_comb begin
    out_idx_d = out_idx_q;
    if (evt) begin
      out_idx_d = (out_idx_q == OUT_LAST) ? '0 : out_idx_q + 1'b1;
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    unique case ({cred_inc, cred_dec})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_idx_q   <= '0;
      out_idx_q  <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_sop_q    <= 1'b0;
      m_eop_q    <= 1'b0;
    end else begin
      in_idx_q   <= in_idx_d;
      out_idx_q  <= out_idx_d;
      inflight_q <= inflight_d;
      m_valid_q  <= evt;
      m_sop_q    <= evt && (out_idx_q == '0);
      m_eop_q    <= evt && (out_idx_q == OUT_LAST);
      if (evt) begin
        m_data_q <= bus.dec_out_byte;
      end
      if (evt && (inflight_q == '0)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = m_data_q;
  assign bus.m_sop     = m_sop_q;
  assign bus.m_eop     = m_eop_q;
  assign bus.inflight  = inflight_q;
  assign bus.err_unexp = err_q;

`ifdef RS_SCHED_STATS_EN
  logic [CNT_W-1:0] in_cnt_q;
  logic [CNT_W-1:0] out_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      if (in_wrap) begin
        in_cnt_q <= in_cnt_q + 1'b1;
      end
      if (m_valid_q && m_eop_q) begin
        out_cnt_q <= out_cnt_q + 1'b1;
      end
    end
  end

  assign bus.in_cw_cnt  = in_cnt_q;
  assign bus.out_cw_cnt = out_cnt_q;
`else
  assign bus.in_cw_cnt  = '0;
  assign bus.out_cw_cnt = '0;
`endif

endmodule

// File: tb/tb_rs_dec_scheduler.sv
// Directed bench for rs_dec_scheduler: pacing, credit, framing,
// coincident credit update, unexpected output and mid-codeword reset.
module tb_rs_dec_scheduler;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   cyc;
  int   pulses;
  int   last_ce;

  rs_dec_scheduler_if bus ();

  rs_dec_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer bytes continuously until n have been accepted.
  task automatic stream(input int n, input bit chk_en);
    int          got;
    int          guard;
    logic        pend;
    logic [7:0]  acc;
    got   = 0;
    guard = 0;
    bus.s_valid = 1'b1;
    while (got < n && guard < n * 8 + 50) begin
      pend = bus.s_ready && bus.s_valid;
      acc  = bus.s_data;
      tick();
      guard++;
      if (pend) begin
        got++;
        bus.s_data = bus.s_data + 8'd1;
      end
      if (chk_en && bus.dec_ce) begin
        chk("dec_byte", {24'd0, bus.dec_byte}, {24'd0, acc});
        if (pulses > 0) chk("ce_period", cyc - last_ce, 8);
        last_ce = cyc;
        pulses++;
      end
    end
    if (got < n) chk("stream_timeout", got, n);
  endtask

  task automatic ev_burst(input int n);
    for (int k = 0; k < n; k++) begin
      bus.dec_valid    = 1'b1;
      bus.dec_ceo      = 1'b1;
      bus.dec_out_byte = 8'(k);
      tick();
    end
    bus.dec_valid = 1'b0;
    bus.dec_ceo   = 1'b0;
  endtask

  initial begin
    int rdy_seen;
    int ce_seen;
    total = 0;
    bad = 0;
    pulses = 0;
    last_ce = 0;
    reset = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data = 8'h00;
    bus.dec_out_byte = 8'h00;
    bus.dec_ceo = 1'b0;
    bus.dec_valid = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dec_ce", bus.dec_ce, 0);
    chk("rst_dec_byte", bus.dec_byte, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_inflight", bus.inflight, 0);
    chk("rst_err", bus.err_unexp, 0);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_in_cnt", bus.in_cw_cnt, 0);
    reset = 1'b0;
    tick();
    chk("idle_s_ready", bus.s_ready, 1);

    // one full codeword at maximum rate
    bus.s_data = 8'h00;
    stream(204, 1'b1);
    chk("cw1_pulses", pulses, 204);
    chk("cw1_inflight", bus.inflight, 1);

    // two more codewords, then credit stalls the fourth
    stream(408, 1'b0);
    chk("cw3_inflight", bus.inflight, 3);
    bus.s_valid = 1'b1;
    rdy_seen = 0;
    ce_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.s_ready) rdy_seen++;
      if (bus.dec_ce) ce_seen++;
    end
    chk("blk_ready", rdy_seen, 0);
    chk("blk_ce", ce_seen, 0);
    chk("blk_inflight", bus.inflight, 3);
    bus.s_valid = 1'b0;

    // valid without CEO is not an event
    bus.dec_valid = 1'b1;
    bus.dec_ceo = 1'b0;
    bus.dec_out_byte = 8'hEE;
    tick();
    chk("no_ceo_valid", bus.m_valid, 0);
    bus.dec_valid = 1'b0;

    // one output codeword frees one credit
    chk("pre_out_ready", bus.s_ready, 0);
    for (int k = 0; k < 188; k++) begin
      bus.dec_valid = 1'b1;
      bus.dec_ceo = 1'b1;
      bus.dec_out_byte = 8'(k);
      tick();
      chk("out_frame",
          {21'd0, bus.m_valid, bus.m_sop, bus.m_eop, bus.m_data},
          {21'd0, 1'b1, k == 0, k == 187, 8'(k)});
    end
    bus.dec_valid = 1'b0;
    bus.dec_ceo = 1'b0;
    chk("out_inflight", bus.inflight, 2);
    chk("out_ready", bus.s_ready, 1);
    tick();
    chk("out_pulse_end", bus.m_valid, 0);
    chk("out_data_hold", bus.m_data, 8'hBB);

    // first-byte accept coinciding with last output event
    ev_burst(187);
    chk("co_pre_inflight", bus.inflight, 2);
    bus.s_valid = 1'b1;
    bus.s_data = 8'hC3;
    bus.dec_valid = 1'b1;
    bus.dec_ceo = 1'b1;
    bus.dec_out_byte = 8'hAB;
    chk("co_ready", bus.s_ready, 1);
    tick();
    bus.s_valid = 1'b0;
    bus.dec_valid = 1'b0;
    bus.dec_ceo = 1'b0;
    chk("co_inflight", bus.inflight, 2);
    chk("co_eop", {bus.m_valid, bus.m_eop, bus.m_sop}, 3'b110);
    chk("co_m_data", bus.m_data, 8'hAB);
    chk("co_ce", {bus.dec_ce, bus.dec_byte}, {1'b1, 8'hC3});

    // unexpected decoder output with no credit in use
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("ue_pre_inflight", bus.inflight, 0);
    bus.dec_valid = 1'b1;
    bus.dec_ceo = 1'b1;
    bus.dec_out_byte = 8'h5A;
    tick();
    bus.dec_valid = 1'b0;
    bus.dec_ceo = 1'b0;
    chk("ue_fwd", {bus.m_valid, bus.m_sop, bus.m_data},
        {1'b1, 1'b1, 8'h5A});
    chk("ue_err", bus.err_unexp, 1);
    chk("ue_inflight", bus.inflight, 0);
    repeat (4) tick();
    chk("ue_err_sticky", bus.err_unexp, 1);
    chk("ue_hold", {bus.m_valid, bus.m_data}, {1'b0, 8'h5A});
    reset = 1'b1;
    tick();
    chk("ue_err_clr", bus.err_unexp, 0);
    reset = 1'b0;

    // reset mid-codeword while in STROBE
    bus.s_data = 8'h00;
    stream(100, 1'b0);
    chk("mid_inflight", bus.inflight, 1);
    stream(1, 1'b0);
    chk("mid_strobe_ce", bus.dec_ce, 1);
    reset = 1'b1;
    tick();
    chk("mid_rst_ce", bus.dec_ce, 0);
    chk("mid_rst_ready", bus.s_ready, 0);
    chk("mid_rst_inflight", bus.inflight, 0);
    chk("mid_rst_byte", bus.dec_byte, 0);
    chk("mid_rst_in_cnt", bus.in_cw_cnt, 0);
    reset = 1'b0;
    bus.s_data = 8'h77;
    stream(1, 1'b0);
    chk("post_rst_ce", {bus.dec_ce, bus.dec_byte}, {1'b1, 8'h77});
    chk("post_rst_inflight", bus.inflight, 1);
    chk("post_rst_out_cnt", bus.out_cw_cnt, 0);
    bus.s_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
